bitop_arbiter: RTL
==================

// Module: bitop_arbiter
// PURPOSE
//  Shared bit-manipulation engine with a 2-requester round-robin arbiter.
//  Ops: bit-reverse (BTR), rotate-left (ROL), rotate-right (ROR) and pass-through.
//  Rotates run iteratively, 1 bit/cycle, to save area. Sits beside the execute stage.
//  Both the execute stage and the debug/test port share one unit.
// PARAMETERS
//  WIDTH  16  operand/result width in bits
//  AMT_W  4   rotate-amount width; must equal log2(WIDTH)
// PORTS
//  clk        in   1         clock; all state changes on rising edge
//  rst_n      in   1         reset, synchronous, active-low
//  req_valid  in   2         per-requester request valid; bit i = requester i
//  req_ready  out  2         per-requester accept; one-hot or zero
//  req_op     in   4         op per requester, [2i+1:2i]: 00 BTR, 01 ROL, 10 ROR, 11 PASS
//  req_data   in   2*WIDTH   operand per requester, [WIDTH*i +: WIDTH]
//  req_amt    in   2*AMT_W   rotate amount per requester, [AMT_W*i +: AMT_W]
//  rsp_valid  out  1         result valid
//  rsp_ready  in   1         consumer accepts result
//  rsp_id     out  1         requester index that owns rsp_data
//  rsp_data   out  WIDTH     result
//  busy       out  1         high whenever state != IDLE
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state=IDLE, rsp_valid=0, rsp_data=0, rsp_id=0, last_grant=1.
//    The internal work register and counter clear to 0. Reset mid-RUN/DONE discards the op.
//  - FSM states: IDLE, RUN, DONE.
//  - IDLE:
//    . req_ready = grant, driven combinationally from req_valid and last_grant.
//    . Single valid requester wins. If both are valid, the requester != last_grant wins.
//    . Accept = req_valid[i] & req_ready[i].
//    . On accept: latch op, data, amt and id; set last_grant=id.
//    . BTR: work = bit-reversed data (work[k] = data[WIDTH-1-k]), go DONE.
//    . PASS, or ROL/ROR with amt==0: work = data, go DONE.
//    . ROL/ROR with amt!=0: work = data, cnt = amt, go RUN.
//  - RUN: req_ready=0. Each cycle work rotates 1 bit in the latched direction and cnt decrements.
//    When cnt==1 at the edge, go DONE.
//  - DONE: rsp_valid=1, with rsp_data=work and rsp_id held stable until rsp_valid & rsp_ready.
//    Then go IDLE. No new accept occurs in the same cycle; the earliest re-accept is the next cycle.
//  - Latency, counted from the accept cycle C0:
//    . BTR/PASS/amt==0: rsp_valid first high in C0+1.
//    . Rotate by amt: rsp_valid first high in C0+amt+1.
//  - req_ready is 0 in RUN and DONE, and 0 in IDLE when no req_valid is high.
//  - Requester handshake: the requester holds op/data/amt stable while valid && !ready.
//    Dropping valid before ready is legal; no request is remembered.
//  - rsp_valid never drops without rsp_ready, under any input. rsp_data/rsp_id are frozen in DONE.
//  - Arithmetic:
//    . Rotates are modulo WIDTH; no carry.
//    . amt is unsigned. Max amt = WIDTH-1 gives latency WIDTH.
//    . cnt is AMT_W bits wide and never wraps.
//  - In DONE, rsp_ready is ignored unless rsp_valid is high, which it always is.
//  - Any req_valid is ignored outside IDLE.
// CONFIGURATION
//  BITOP_FIXED_PRIO_EN defined:
//    . Requester 0 always wins when both are valid; last_grant is unused.
//    . The requester-1 starvation hazard is accepted.
//  BITOP_FIXED_PRIO_EN undefined (default): round-robin as above.
//  No other behaviour changes.
// TESTING
//  1. R0 BTR data=0x0001 -> rsp_valid in C0+1, rsp_data=0x8000, rsp_id=0, busy high C1 only.
//  2. R1 ROL data=0x8001 amt=3 -> rsp_valid first in C0+4, rsp_data=0x000C, rsp_id=1.
//     R0 ROR data=0x0001 amt=15 -> rsp_data=0x0002 in C0+16.
//  3. Both valid continuously, PASS data=0x1234/0x5678, rsp_ready=1, 4 ops:
//     default -> rsp_id sequence 0,1,0,1.
//     With BITOP_FIXED_PRIO_EN -> rsp_id sequence 0,0,0,0.
//  4. R0 BTR 0x00FF with rsp_ready=0 for 5 cycles -> rsp_valid=1, rsp_data=0xFF00 held.
//     req_ready=2'b00 throughout. Response accepted on the cycle rsp_ready rises.
//  5. R0 ROL amt=8 and rst_n=0 in C0+3 -> next cycle: state IDLE, rsp_valid=0, busy=0, rsp_data=0.
//     A fresh R1 request then wins first (last_grant=1 reset -> R0 wins ties; R1 only valid).
//  6. R1 ROR amt=0 data=0xA5A5 -> rsp_valid C0+1, rsp_data=0xA5A5; RUN never entered.

Source files
------------

// File: rtl/bitop_arbiter.sv
// Shared bit-reverse/rotate engine behind a 2-requester round-robin arbiter; rotates run 1 bit/cycle.
// Define BITOP_FIXED_PRIO_EN to replace round-robin with fixed priority (requester 0 wins ties).
module bitop_arbiter #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [3:0]           req_op,
  input  logic [2*WIDTH-1:0]   req_data,
  input  logic [2*AMT_W-1:0]   req_amt,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [WIDTH-1:0]     rsp_data,
  output logic                 busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_BTR  = 2'b00;
  localparam logic [1:0] OP_ROL  = 2'b01;
  localparam logic [1:0] OP_ROR  = 2'b10;

  logic [1:0]       state;
  logic [WIDTH-1:0] work;
  logic [AMT_W-1:0] cnt;
  logic             dir_right;
  logic             id;
`ifndef BITOP_FIXED_PRIO_EN
  logic             last_grant;
`endif

  logic             gid;
  logic [1:0]       op_sel;
  logic [WIDTH-1:0] data_sel;
  logic [AMT_W-1:0] amt_sel;
  logic [WIDTH-1:0] data_rev;
  logic             is_rot;

  always_comb begin
    gid = 1'b0;
    case (req_valid)
      2'b01:   gid = 1'b0;
      2'b10:   gid = 1'b1;
`ifdef BITOP_FIXED_PRIO_EN
      2'b11:   gid = 1'b0;
`else
      2'b11:   gid = ~last_grant;
`endif
      default: gid = 1'b0;
    endcase
  end

  // Grant only exists in IDLE; the ready is the arbiter's one-hot decision.
  always_comb begin
    req_ready = 2'b00;
    if (state == S_IDLE && |req_valid) begin
      req_ready = gid ? 2'b10 : 2'b01;
    end
  end

  assign op_sel   = gid ? req_op[3:2] : req_op[1:0];
  assign data_sel = gid ? req_data[2*WIDTH-1:WIDTH] : req_data[WIDTH-1:0];
  assign amt_sel  = gid ? req_amt[2*AMT_W-1:AMT_W] : req_amt[AMT_W-1:0];
  assign is_rot   = (op_sel == OP_ROL) || (op_sel == OP_ROR);

  always_comb begin
    data_rev = '0;
    for (int k = 0; k < WIDTH; k++) begin
      data_rev[k] = data_sel[WIDTH-1-k];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      work       <= '0;
      cnt        <= '0;
      dir_right  <= 1'b0;
      id         <= 1'b0;
`ifndef BITOP_FIXED_PRIO_EN
      last_grant <= 1'b1;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (|req_valid) begin
            id         <= gid;
`ifndef BITOP_FIXED_PRIO_EN
            last_grant <= gid;
`endif
            dir_right  <= (op_sel == OP_ROR);
            if (op_sel == OP_BTR) begin
              work  <= data_rev;
              state <= S_DONE;
            end else begin
              work <= data_sel;
              if (is_rot && amt_sel != '0) begin
                cnt   <= amt_sel;
                state <= S_RUN;
              end else begin
                state <= S_DONE;
              end
            end
          end
        end
        S_RUN: begin
          work <= dir_right ? {work[0], work[WIDTH-1:1]} : {work[WIDTH-2:0], work[WIDTH-1]};
          cnt  <= cnt - 1'b1;
          if (cnt == AMT_W'(1)) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid = (state == S_DONE);
  assign rsp_data  = work;
  assign rsp_id    = id;
  assign busy      = (state != S_IDLE);

endmodule
